// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game types: spawner states, LFSR mask and step, despawn guard length
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE_XY,
    WRITE_DXY,
    ACTIVE,
    COOLDOWN
  } spawner_state_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [1:0]  GUARD_LEN = 2'd2;

  // Galois step: shift right, fold the mask in when a one falls off the bottom
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/game_lfsr16.sv
// rtl/game_lfsr16.sv - free-running 16-bit Galois LFSR shared by the random game blocks
module game_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);
  import game_pkg::*;

  // an all-zero LFSR would lock up, so a zero seed starts from 1
  localparam logic [15:0] RESET_VALUE = (SEED == 16'h0000) ? 16'h0001 : SEED;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_VALUE;
    end else begin
      state <= lfsr16_next(state);
    end
  end

endmodule

// File: rtl/game_sprite_spawner.sv
// rtl/game_sprite_spawner.sv - spawn/despawn/respawn driver for one sprite; GAME_SPRITE_SPAWNER_RANDOM_DX_EN randomises dx
module game_sprite_spawner #(
  parameter int          SPRITE_WIDTH  = 16,
  parameter int          DX_WIDTH      = 2,
  parameter int          DY_WIDTH      = 2,
  parameter int          DX_INIT       = 0,
  parameter int          DY_INIT       = 1,
  parameter int          SPAWN_Y       = 0,
  parameter int          RESPAWN_DELAY = 1000,
  parameter logic [15:0] SEED          = 16'hACE1,
  parameter int          screen_width  = 640,
  parameter int          screen_height = 480,
  parameter int          w_x           = $clog2(screen_width),
  parameter int          w_y           = $clog2(screen_height)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                hit,
  input  logic                sprite_within_screen,
  output logic                sprite_write_xy,
  output logic                sprite_write_dxy,
  output logic [w_x-1:0]      sprite_write_x,
  output logic [w_y-1:0]      sprite_write_y,
  output logic [DX_WIDTH-1:0] sprite_write_dx,
  output logic [DY_WIDTH-1:0] sprite_write_dy,
  output logic                sprite_enable_update,
  output logic [7:0]          spawn_count
);
  import game_pkg::*;

  localparam int            CW        = (RESPAWN_DELAY > 1) ? $clog2(RESPAWN_DELAY) : 1;
  localparam logic [CW-1:0] COOL_LOAD = CW'(RESPAWN_DELAY - 1);
  localparam logic [w_x:0]  X_MAX     = (w_x + 1)'(screen_width - SPRITE_WIDTH);
  localparam logic [w_x-1:0] X_WRAP   = w_x'(screen_width - SPRITE_WIDTH + 1);

  spawner_state_t state;
  logic [CW-1:0]  cool_cnt;
  logic [1:0]     guard_cnt;
  logic [15:0]    lfsr;
  logic [w_x-1:0] lfsr_x;
  logic [w_x-1:0] spawn_x;
  logic [DX_WIDTH-1:0] spawn_dx;
  logic           spawn_now;
  logic           despawn;
  logic           unused_lfsr;

  game_lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr)
  );

  // a single conditional subtraction folds the raw value onto 0..M because 2*(M+1) covers the raw range
  assign lfsr_x  = lfsr[w_x-1:0];
  assign spawn_x = ({1'b0, lfsr_x} <= X_MAX) ? lfsr_x : lfsr_x - X_WRAP;

`ifdef GAME_SPRITE_SPAWNER_RANDOM_DX_EN
  assign spawn_dx = lfsr[15 -: DX_WIDTH];
`else
  assign spawn_dx = DX_WIDTH'(DX_INIT);
`endif

  assign unused_lfsr = ^lfsr;

  assign spawn_now = (state == IDLE) || (state == COOLDOWN && cool_cnt == '0);
  // right after motion starts the sprite may still report the previous life's off-screen status
  assign despawn   = hit || (guard_cnt == GUARD_LEN && !sprite_within_screen);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      cool_cnt             <= '0;
      guard_cnt            <= '0;
      sprite_write_xy      <= 1'b0;
      sprite_write_dxy     <= 1'b0;
      sprite_write_x       <= '0;
      sprite_write_y       <= '0;
      sprite_write_dx      <= '0;
      sprite_write_dy      <= '0;
      sprite_enable_update <= 1'b0;
      spawn_count          <= '0;
    end else if (!enable) begin
      state                <= IDLE;
      sprite_write_xy      <= 1'b0;
      sprite_write_dxy     <= 1'b0;
      sprite_enable_update <= 1'b0;
    end else begin
      sprite_write_xy  <= 1'b0;
      sprite_write_dxy <= 1'b0;
      if (spawn_now) begin
        state           <= WRITE_XY;
        sprite_write_xy <= 1'b1;
        sprite_write_x  <= spawn_x;
        sprite_write_y  <= w_y'(SPAWN_Y);
        if (spawn_count != 8'hFF) begin
          spawn_count <= spawn_count + 8'd1;
        end
      end else begin
        case (state)
          WRITE_XY: begin
            state            <= WRITE_DXY;
            sprite_write_dxy <= 1'b1;
            sprite_write_dx  <= spawn_dx;
            sprite_write_dy  <= DY_WIDTH'(DY_INIT);
          end
          WRITE_DXY: begin
            state                <= ACTIVE;
            sprite_enable_update <= 1'b1;
            guard_cnt            <= '0;
          end
          ACTIVE: begin
            if (guard_cnt != GUARD_LEN) begin
              guard_cnt <= guard_cnt + 2'd1;
            end
            if (despawn) begin
              state                <= COOLDOWN;
              sprite_enable_update <= 1'b0;
              cool_cnt             <= COOL_LOAD;
            end
          end
          COOLDOWN: begin
            cool_cnt <= cool_cnt - CW'(1);
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_sprite_spawner.sv
// tb/tb_game_sprite_spawner.sv - randomized self-checking bench for game_sprite_spawner
module tb_game_sprite_spawner;
  import game_pkg::*;

  localparam int DELAY   = 4;
  localparam int X_LIMIT = 640 - 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       hit = 1'b0;
  logic       sprite_within_screen = 1'b1;
  logic       sprite_write_xy;
  logic       sprite_write_dxy;
  logic [9:0] sprite_write_x;
  logic [8:0] sprite_write_y;
  logic [1:0] sprite_write_dx;
  logic [1:0] sprite_write_dy;
  logic       sprite_enable_update;
  logic [7:0] spawn_count;

  int n_checks = 0;
  int n_fail = 0;
  int exp_count = 0;
  logic [15:0] ref_lfsr;
  logic [15:0] ref_prev;

  game_sprite_spawner #(
    .SPRITE_WIDTH  (16),
    .DX_WIDTH      (2),
    .DY_WIDTH      (2),
    .DX_INIT       (3),
    .DY_INIT       (1),
    .SPAWN_Y       (0),
    .RESPAWN_DELAY (DELAY),
    .SEED          (16'h0000),
    .screen_width  (640),
    .screen_height (480)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .enable               (enable),
    .hit                  (hit),
    .sprite_within_screen (sprite_within_screen),
    .sprite_write_xy      (sprite_write_xy),
    .sprite_write_dxy     (sprite_write_dxy),
    .sprite_write_x       (sprite_write_x),
    .sprite_write_y       (sprite_write_y),
    .sprite_write_dx      (sprite_write_dx),
    .sprite_write_dy      (sprite_write_dy),
    .sprite_enable_update (sprite_enable_update),
    .spawn_count          (spawn_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic int ref_fold(input logic [15:0] s);
    int r;
    r = int'(s[9:0]);
    return (r <= X_LIMIT) ? r : r - (X_LIMIT + 1);
  endfunction

  // ref_prev is the value the design sampled at the most recent edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_lfsr <= 16'h0001;
      ref_prev <= 16'h0001;
    end else begin
      ref_prev <= ref_lfsr;
      ref_lfsr <= ref_step(ref_lfsr);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // entered at the negedge of the WRITE_XY cycle, leaves at the negedge of the first ACTIVE cycle
  task automatic check_spawn_seq(input string tag);
    int exp_x;
    logic [1:0] exp_dx;
    exp_x = ref_fold(ref_prev);
    exp_count = (exp_count < 255) ? exp_count + 1 : 255;
    n_checks++;
    if (sprite_write_xy !== 1'b1 || sprite_write_dxy !== 1'b0 || sprite_enable_update !== 1'b0) begin
      n_fail++;
      $display("FAIL %s xy_strobes xy=%b dxy=%b upd=%b expected 1 0 0", tag, sprite_write_xy, sprite_write_dxy, sprite_enable_update);
    end
    n_checks++;
    if (sprite_write_x !== 10'(exp_x) || sprite_write_y !== 9'd0 || int'(sprite_write_x) > X_LIMIT) begin
      n_fail++;
      $display("FAIL %s spawn_xy x=%0d y=%0d expected x=%0d y=0", tag, sprite_write_x, sprite_write_y, exp_x);
    end
    n_checks++;
    if (spawn_count !== 8'(exp_count)) begin
      n_fail++;
      $display("FAIL %s spawn_count got %0d expected %0d", tag, spawn_count, exp_count);
    end
    tick();
`ifdef GAME_SPRITE_SPAWNER_RANDOM_DX_EN
    exp_dx = ref_prev[15:14];
`else
    exp_dx = 2'b11;
`endif
    n_checks++;
    if (sprite_write_xy !== 1'b0 || sprite_write_dxy !== 1'b1 || sprite_enable_update !== 1'b0
        || sprite_write_dx !== exp_dx || sprite_write_dy !== 2'd1) begin
      n_fail++;
      $display("FAIL %s dxy_cycle xy=%b dxy=%b upd=%b dx=%b dy=%b expected 0 1 0 dx=%b dy=01", tag,
               sprite_write_xy, sprite_write_dxy, sprite_enable_update, sprite_write_dx, sprite_write_dy, exp_dx);
    end
    tick();
    n_checks++;
    if (sprite_write_xy !== 1'b0 || sprite_write_dxy !== 1'b0 || sprite_enable_update !== 1'b1) begin
      n_fail++;
      $display("FAIL %s active_start xy=%b dxy=%b upd=%b expected 0 0 1", tag, sprite_write_xy, sprite_write_dxy, sprite_enable_update);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({sprite_write_xy, sprite_write_dxy, sprite_write_x, sprite_write_y, sprite_write_dx,
         sprite_write_dy, sprite_enable_update, spawn_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs some output nonzero: xy=%b dxy=%b x=%0d y=%0d upd=%b cnt=%0d expected all 0",
               sprite_write_xy, sprite_write_dxy, sprite_write_x, sprite_write_y, sprite_enable_update, spawn_count);
    end
    n_checks++;
    if (dut.u_lfsr.state !== 16'h0001) begin
      n_fail++;
      $display("FAIL reset_lfsr got %h expected 0001", dut.u_lfsr.state);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (sprite_write_xy !== 1'b0 || sprite_write_dxy !== 1'b0 || sprite_enable_update !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_quiet cycle %0d xy=%b dxy=%b upd=%b expected 0 0 0", i, sprite_write_xy, sprite_write_dxy, sprite_enable_update);
      end
    end
  endtask

  task automatic test_first_spawn();
    sprite_within_screen = 1'b1;
    enable = 1'b1;
    tick();
    check_spawn_seq("first_spawn");
  endtask

  task automatic test_guard();
    sprite_within_screen = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      n_checks++;
      if (sprite_enable_update !== 1'b1) begin
        n_fail++;
        $display("FAIL guard active cycle %0d upd=%b expected 1", i, sprite_enable_update);
      end
    end
    for (int i = 1; i <= DELAY; i++) begin
      tick();
      sprite_within_screen = 1'b1;
      n_checks++;
      if (sprite_enable_update !== 1'b0 || sprite_write_xy !== 1'b0) begin
        n_fail++;
        $display("FAIL guard_cooldown K+%0d upd=%b xy=%b expected 0 0", i, sprite_enable_update, sprite_write_xy);
      end
    end
    tick();
    check_spawn_seq("guard_respawn");
  endtask

  task automatic test_random_despawn();
    int mode;
    int w;
    int d;
    for (int r = 0; r < 10; r++) begin
      mode = (r == 0) ? 1 : int'($urandom_range(0, 1));
      w = (r == 0) ? 3 : int'($urandom_range(0, 5));
      d = (mode == 1) ? w : ((w < 2) ? 2 : w);
      for (int c = 0; c <= d; c++) begin
        if (mode == 1) begin
          hit = (c == w);
          sprite_within_screen = !((c == w) && (r == 0 || $urandom_range(0, 1) == 1));
        end else begin
          sprite_within_screen = (c < w);
        end
        n_checks++;
        if (sprite_enable_update !== 1'b1) begin
          n_fail++;
          $display("FAIL random r%0d active cycle %0d upd=%b expected 1", r, c, sprite_enable_update);
        end
        if (c < d) tick();
      end
      tick();
      hit = 1'b0;
      sprite_within_screen = 1'b1;
      for (int i = 1; i <= DELAY; i++) begin
        n_checks++;
        if (sprite_enable_update !== 1'b0 || sprite_write_xy !== 1'b0) begin
          n_fail++;
          $display("FAIL random r%0d cooldown K+%0d upd=%b xy=%b expected 0 0", r, i, sprite_enable_update, sprite_write_xy);
        end
        hit = 1'($urandom_range(0, 1));
        tick();
      end
      hit = 1'b0;
      check_spawn_seq("random_respawn");
    end
  endtask

  task automatic test_enable_drop();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    exp_count = (exp_count < 255) ? exp_count + 1 : 255;
    n_checks++;
    if (sprite_write_xy !== 1'b1 || spawn_count !== 8'(exp_count)) begin
      n_fail++;
      $display("FAIL drop_xy xy=%b cnt=%0d expected 1 %0d", sprite_write_xy, spawn_count, exp_count);
    end
    tick();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (sprite_write_xy !== 1'b0 || sprite_write_dxy !== 1'b0 || sprite_enable_update !== 1'b0
          || dut.state !== IDLE || spawn_count !== 8'(exp_count)) begin
        n_fail++;
        $display("FAIL drop_idle cycle %0d xy=%b dxy=%b upd=%b cnt=%0d expected 0 0 0 cnt=%0d in IDLE",
                 i, sprite_write_xy, sprite_write_dxy, sprite_enable_update, spawn_count, exp_count);
      end
    end
    enable = 1'b1;
    tick();
    check_spawn_seq("drop_return");
  endtask

  task automatic test_saturate();
    int exp_x;
    enable = 1'b0;
    tick();
    for (int i = 0; i < 300; i++) begin
      enable = 1'b1;
      tick();
      exp_x = ref_fold(ref_prev);
      exp_count = (exp_count < 255) ? exp_count + 1 : 255;
      n_checks++;
      if (sprite_write_xy !== 1'b1 || sprite_write_x !== 10'(exp_x)) begin
        n_fail++;
        $display("FAIL saturate spawn %0d xy=%b x=%0d expected 1 %0d", i, sprite_write_xy, sprite_write_x, exp_x);
      end
      enable = 1'b0;
      tick();
    end
    n_checks++;
    if (spawn_count !== 8'd255 || exp_count != 255) begin
      n_fail++;
      $display("FAIL saturate_count got %0d expected 255", spawn_count);
    end
  endtask

  task automatic test_async_reset();
    enable = 1'b1;
    tick();
    tick();
    tick();
    n_checks++;
    if (sprite_enable_update !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre upd=%b expected 1", sprite_enable_update);
    end
    #2 rst = 1'b1;
    #1;
    exp_count = 0;
    n_checks++;
    if (sprite_enable_update !== 1'b0 || spawn_count !== 8'd0 || sprite_write_x !== 10'd0 || sprite_write_dx !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset upd=%b cnt=%0d x=%0d dx=%b expected all 0", sprite_enable_update, spawn_count, sprite_write_x, sprite_write_dx);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_spawn_seq("after_reset");
  endtask

  initial begin
    #2;
    test_reset();
    test_first_spawn();
    test_guard();
    test_random_despawn();
    test_enable_drop();
    test_saturate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
